alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 210 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: command sequencer for an external combinational 8-bit ALU.
//
// Commands are queued in a small FIFO. A three-state FSM (IDLE, ISSUE, WB)
// pops one command at a time. It reads the operands from an 8 x 8 register
// file, drives them to the external ALU, captures the ALU response and
// writes the result back. r0 is hardwired to zero.
//
// Optional feature: define ALU_SEQ_ZFLAG_EN to add the zero_flag output.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   cmd_valid / cmd_ready      command handshake (ready = FIFO not full)
//   cmd_op, cmd_rd, cmd_rs1,
//   cmd_rs2, cmd_imm,
//   cmd_imm_sel, cmd_use_c     command fields
//   alu_in1, alu_in2,
//   alu_cin, alu_func          operands driven to the external ALU
//   alu_result, alu_cout       combinational ALU response
//   done, done_data            one-cycle writeback pulse and written value
//   carry_flag                 last stored carry
//   busy                       FSM active or commands queued
//   zero_flag                  (ALU_SEQ_ZFLAG_EN only) last result was zero
//   dbg_addr, dbg_data         combinational register-file read port
module alu_seq #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [2:0] cmd_rd,
    input  logic [2:0] cmd_rs1,
    input  logic [2:0] cmd_rs2,
    input  logic [7:0] cmd_imm,
    input  logic       cmd_imm_sel,
    input  logic       cmd_use_c,
    output logic [7:0] alu_in1,
    output logic [7:0] alu_in2,
    output logic       alu_cin,
    output logic [2:0] alu_func,
    input  logic [7:0] alu_result,
    input  logic       alu_cout,
    output logic       done,
    output logic [7:0] done_data,
    output logic       carry_flag,
    output logic       busy,
`ifdef ALU_SEQ_ZFLAG_EN
    output logic       zero_flag,
`endif
    input  logic [2:0] dbg_addr,
    output logic [7:0] dbg_data
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [2:0] op;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [7:0] imm;
        logic       imm_sel;
        logic       use_c;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;

    cmd_t             fifo_mem [FIFO_DEPTH];
    cmd_t             cmd_in;
    cmd_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    logic [7:0]       rf [8];
    logic [2:0]       rd_q;
    logic             cout_q;

    assign cmd_in = '{op: cmd_op, rd: cmd_rd, rs1: cmd_rs1, rs2: cmd_rs2,
                      imm: cmd_imm, imm_sel: cmd_imm_sel, use_c: cmd_use_c};

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && !empty;
    assign head      = fifo_mem[rd_ptr];
    assign busy      = (state != IDLE) || !empty;
    assign dbg_data  = (dbg_addr == 3'd0) ? 8'h00 : rf[dbg_addr];

    // Entry storage needs no reset: the empty count guards stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cmd_in;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                next_state = WB;
            end
            WB: begin
                next_state = IDLE;
                done       = 1'b1;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operands are read at pop time. The preceding WB write has already
    // landed by then, so dependent commands need no bypass. The alu_*
    // registers load only on pop and otherwise hold their value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_in1    <= 8'h00;
            alu_in2    <= 8'h00;
            alu_cin    <= 1'b0;
            alu_func   <= 3'd0;
            rd_q       <= 3'd0;
            cout_q     <= 1'b0;
            done_data  <= 8'h00;
            carry_flag <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                rf[i] <= 8'h00;
            end
        end else begin
            if (pop) begin
                alu_in1  <= rf[head.rs1];
                alu_in2  <= head.imm_sel ? head.imm : rf[head.rs2];
                alu_cin  <= head.use_c & carry_flag;
                alu_func <= head.op;
                rd_q     <= head.rd;
            end
            if (state == ISSUE) begin
                done_data <= alu_result;
                cout_q    <= alu_cout;
            end
            if (state == WB) begin
                carry_flag <= cout_q;
                if (rd_q != 3'd0) begin
                    rf[rd_q] <= done_data;
                end
            end
        end
    end

`ifdef ALU_SEQ_ZFLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_flag <= 1'b0;
        end else if (state == WB) begin
            zero_flag <= (done_data == 8'h00);
        end
    end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq with a behavioural 8-bit ALU.
// Expected writeback values are queued as commands are issued. A monitor
// pops the queue and compares on every done pulse.
`timescale 1ns/1ps
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [2:0] cmd_rd = '0;
    logic [2:0] cmd_rs1 = '0;
    logic [2:0] cmd_rs2 = '0;
    logic [7:0] cmd_imm = '0;
    logic       cmd_imm_sel = 1'b0;
    logic       cmd_use_c = 1'b0;
    logic [7:0] alu_in1;
    logic [7:0] alu_in2;
    logic       alu_cin;
    logic [2:0] alu_func;
    logic [7:0] alu_result;
    logic       alu_cout;
    logic       done;
    logic [7:0] done_data;
    logic       carry_flag;
    logic       busy;
`ifdef ALU_SEQ_ZFLAG_EN
    logic       zero_flag;
`endif
    logic [2:0] dbg_addr = '0;
    logic [7:0] dbg_data;

    int         checks = 0;
    int         failures = 0;
    int         cycle = 0;
    int         done_count = 0;
    int         saved_done_count = 0;
    logic [7:0] sb_q [$];
    int         done_cycles [$];
    logic [7:0] mon_exp;
    logic [8:0] alu_tmp;

    alu_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rd     (cmd_rd),
        .cmd_rs1    (cmd_rs1),
        .cmd_rs2    (cmd_rs2),
        .cmd_imm    (cmd_imm),
        .cmd_imm_sel(cmd_imm_sel),
        .cmd_use_c  (cmd_use_c),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_cin    (alu_cin),
        .alu_func   (alu_func),
        .alu_result (alu_result),
        .alu_cout   (alu_cout),
        .done       (done),
        .done_data  (done_data),
        .carry_flag (carry_flag),
        .busy       (busy),
`ifdef ALU_SEQ_ZFLAG_EN
        .zero_flag  (zero_flag),
`endif
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Behavioural ALU: SUB carry-out is the borrow, shifts push out the lost bit.
    always_comb begin
        alu_tmp = 9'h000;
        case (alu_func)
            3'd0: alu_tmp = {1'b0, alu_in1} + {1'b0, alu_in2} + {8'h00, alu_cin};
            3'd1: alu_tmp = {1'b0, alu_in1} - {1'b0, alu_in2} - {8'h00, alu_cin};
            3'd2: alu_tmp = {1'b0, alu_in2};
            3'd3: alu_tmp = {alu_in1, 1'b0};
            3'd4: alu_tmp = {alu_in1[0], 1'b0, alu_in1[7:1]};
            3'd5: alu_tmp = {1'b0, alu_in1 & alu_in2};
            3'd6: alu_tmp = {1'b0, ~alu_in1};
            3'd7: alu_tmp = {1'b0, alu_in1 | alu_in2};
            default: alu_tmp = 9'h000;
        endcase
    end
    assign alu_result = alu_tmp[7:0];
    assign alu_cout   = alu_tmp[8];

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done) begin
            done_count++;
            done_cycles.push_back(cycle);
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL done_unexpected actual=0x%02h required=no done pulse", done_data);
            end else begin
                mon_exp = sb_q.pop_front();
                if (done_data !== mon_exp) begin
                    failures++;
                    $display("[TB] FAIL done_data actual=0x%02h required=0x%02h", done_data, mon_exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkReg(input string name, input logic [2:0] addr, input logic [7:0] expected);
        dbg_addr = addr;
        #1;
        checkOutput(name, {24'h0, dbg_data}, {24'h0, expected});
    endtask

    task automatic alignEdge();
        @(posedge clk);
        #1;
    endtask

    // Offers one command and returns 1ns after the accepting edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                                 input logic [2:0] rs2, input logic [7:0] imm, input logic imm_sel,
                                 input logic use_c, input bit expect_done, input logic [7:0] exp_data);
        bit   accepted;
        logic ready_s;
        accepted = 1'b0;
        if (expect_done) sb_q.push_back(exp_data);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_rd      = rd;
        cmd_rs1     = rs1;
        cmd_rs2     = rs2;
        cmd_imm     = imm;
        cmd_imm_sel = imm_sel;
        cmd_use_c   = use_c;
        for (int i = 0; i < 64 && !accepted; i++) begin
            @(negedge clk);
            ready_s = cmd_ready;
            @(posedge clk);
            if (ready_s) accepted = 1'b1;
        end
        #1;
        cmd_valid = 1'b0;
        if (!accepted) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout actual=not accepted required=accepted");
        end
    endtask

    task automatic waitIdle(input string name);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 100 && !idle; i++) begin
            @(negedge clk);
            if (!busy) idle = 1'b1;
        end
        if (!idle) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s actual=busy required=idle", name);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        $display("[TB] start");
        #1 rst_n = 1'b0;
        #3;
        checkOutput("rst_cmd_ready", cmd_ready, 1);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done_data", done_data, 0);
        checkOutput("rst_carry", carry_flag, 0);
        checkOutput("rst_alu_in1", alu_in1, 0);
        checkOutput("rst_alu_func", alu_func, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        alignEdge();
        checkOutput("post_rst_ready", cmd_ready, 1);

        // First command with latency and operand-hold checks.
        applyStimulus(3'd0, 3'd1, 3'd0, 3'd0, 8'h05, 1'b1, 1'b0, 1'b1, 8'h05);
        dbg_addr = 3'd1;
        @(posedge clk); #1;
        checkOutput("issue_done_low", done, 0);
        checkOutput("issue_alu_in1", alu_in1, 8'h00);
        checkOutput("issue_alu_in2", alu_in2, 8'h05);
        checkOutput("issue_alu_func", alu_func, 0);
        @(posedge clk); #1;
        checkOutput("wb_done_high", done, 1);
        checkOutput("wb_dbg_prewrite", dbg_data, 8'h00);
        @(posedge clk); #1;
        checkOutput("after_wb_done_low", done, 0);
        checkOutput("after_wb_dbg_new", dbg_data, 8'h05);
        checkOutput("hold_alu_in2", alu_in2, 8'h05);
        waitIdle("idle_first");

        // Carry out of 0xFF + 1.
        applyStimulus(3'd0, 3'd1, 3'd0, 3'd0, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF);
        waitIdle("idle_load_ff");
        applyStimulus(3'd0, 3'd2, 3'd1, 3'd0, 8'h01, 1'b1, 1'b0, 1'b1, 8'h00);
        waitIdle("idle_carry");
        checkOutput("carry_set", carry_flag, 1);
`ifdef ALU_SEQ_ZFLAG_EN
        checkOutput("zero_flag_set", zero_flag, 1);
`endif
        checkReg("r2_zero", 3'd2, 8'h00);

        // Carry-in taken from carry_flag at pop time.
        alignEdge();
        applyStimulus(3'd0, 3'd5, 3'd0, 3'd0, 8'h10, 1'b1, 1'b1, 1'b1, 8'h11);
        waitIdle("idle_use_c");
        checkOutput("carry_clear", carry_flag, 0);
        checkReg("r5_use_c", 3'd5, 8'h11);

        // Writes to r0 are discarded.
        alignEdge();
        applyStimulus(3'd0, 3'd0, 3'd0, 3'd0, 8'h80, 1'b1, 1'b0, 1'b1, 8'h80);
        waitIdle("idle_r0");
        checkReg("r0_stays_zero", 3'd0, 8'h00);

        // Back-to-back dependent commands, 3 cycles apart.
        done_cycles.delete();
        applyStimulus(3'd0, 3'd1, 3'd0, 3'd0, 8'h03, 1'b1, 1'b0, 1'b1, 8'h03);
        applyStimulus(3'd1, 3'd3, 3'd1, 3'd1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);
        applyStimulus(3'd7, 3'd4, 3'd3, 3'd0, 8'h10, 1'b1, 1'b0, 1'b1, 8'h10);
        waitIdle("idle_dep");
        checkOutput("dep_done_count", done_cycles.size(), 3);
        if (done_cycles.size() == 3) begin
            checkOutput("dep_spacing_1", done_cycles[1] - done_cycles[0], 3);
            checkOutput("dep_spacing_2", done_cycles[2] - done_cycles[1], 3);
        end
        checkReg("r3_sub", 3'd3, 8'h00);
        checkReg("r4_or", 3'd4, 8'h10);

        // Remaining ALU functions, then borrow feeding carry-in.
        alignEdge();
        applyStimulus(3'd3, 3'd5, 3'd4, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h20);
        applyStimulus(3'd4, 3'd6, 3'd4, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h08);
        applyStimulus(3'd5, 3'd7, 3'd1, 3'd0, 8'h01, 1'b1, 1'b0, 1'b1, 8'h01);
        applyStimulus(3'd6, 3'd6, 3'd4, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hEF);
        applyStimulus(3'd2, 3'd7, 3'd0, 3'd0, 8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C);
        applyStimulus(3'd1, 3'd5, 3'd0, 3'd0, 8'h01, 1'b1, 1'b0, 1'b1, 8'hFF);
        applyStimulus(3'd0, 3'd5, 3'd1, 3'd4, 8'h00, 1'b0, 1'b1, 1'b1, 8'h14);
        waitIdle("idle_ops");
        checkReg("r5_add_c", 3'd5, 8'h14);
        checkReg("r6_not", 3'd6, 8'hEF);
        checkReg("r7_assign", 3'd7, 8'h3C);

        // Burst: with one pop every 3 cycles the 4-entry FIFO fills on the 6th accept.
        alignEdge();
        for (int k = 0; k < 7; k++) begin
            applyStimulus(3'd0, 3'(k + 1), 3'd0, 3'd0, 8'(8'hA1 + k), 1'b1, 1'b0, 1'b1, 8'(8'hA1 + k));
            if (k == 5) checkOutput("ready_low_when_full", cmd_ready, 0);
        end
        waitIdle("idle_burst");
        checkReg("burst_r1", 3'd1, 8'hA1);
        checkReg("burst_r7", 3'd7, 8'hA7);

        // Reset while the second command is in ISSUE with two more queued.
        alignEdge();
        applyStimulus(3'd0, 3'd1, 3'd0, 3'd0, 8'h55, 1'b1, 1'b0, 1'b1, 8'h55);
        applyStimulus(3'd0, 3'd2, 3'd0, 3'd0, 8'h66, 1'b1, 1'b0, 1'b0, 8'h00);
        applyStimulus(3'd0, 3'd3, 3'd0, 3'd0, 8'h77, 1'b1, 1'b0, 1'b0, 8'h00);
        applyStimulus(3'd0, 3'd4, 3'd0, 3'd0, 8'h88, 1'b1, 1'b0, 1'b0, 8'h00);
        @(posedge clk); #1;
        checkOutput("pre_rst_issue_in2", alu_in2, 8'h66);
        checkOutput("pre_rst_busy", busy, 1);
        saved_done_count = done_count;
        rst_n = 1'b0;
        #2;
        checkOutput("mid_rst_done", done, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_ready", cmd_ready, 1);
        checkOutput("mid_rst_alu_in2", alu_in2, 8'h00);
        checkOutput("mid_rst_done_data", done_data, 8'h00);
        for (int r = 0; r < 8; r++) begin
            checkReg("mid_rst_rf", 3'(r), 8'h00);
        end
        @(negedge clk) rst_n = 1'b1;
        alignEdge();
        checkOutput("release_ready", cmd_ready, 1);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("no_done_after_rst", done_count, saved_done_count);
        checkOutput("idle_after_rst", busy, 0);

        // Normal operation resumes after reset.
        applyStimulus(3'd0, 3'd1, 3'd0, 3'd0, 8'h07, 1'b1, 1'b0, 1'b1, 8'h07);
        waitIdle("idle_final");
        checkReg("final_r1", 3'd1, 8'h07);
        checkOutput("scoreboard_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
